approx_or_adder_pipe: RTL

Pipelined, parametrised lower-part-OR approximate adder for the Laplace filter datapath, with a characterisation unit on the side. Operand width and the maximum approximate LSB count are compile-time parameters. The number of OR-approximated LSBs is selected per transaction at run time, with 0 meaning an exact add. Operands move through a two-stage valid/ready pipeline. A built-in error monitor accumulates absolute error against the exact sum, so characterisation runs no longer need offline file dumps.

---
 rtl/approx_or_adder_pipe.sv | 126 ++++++++++++
 1 files changed

// File: rtl/approx_or_adder_pipe.sv
// Two-stage lower-part-OR approximate adder with run-time selectable approximate
// LSB count and an on-board absolute-error monitor for characterisation runs.
module approx_or_adder_pipe #(
  parameter int WIDTH = 8,
  parameter int MAX_K = 4,
  parameter int ACC_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             A,
  input  logic [WIDTH-1:0]             B,
  input  logic                         Cin,
  input  logic [$clog2(MAX_K+1)-1:0]   K,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             S,
  output logic                         Cout,
  input  logic                         stats_clr,
  output logic [ACC_W-1:0]             err_acc,
  output logic [ACC_W-1:0]             err_cnt,
  output logic [WIDTH:0]               err_max
);

  localparam int KW = $clog2(MAX_K+1);
  localparam int DW = WIDTH + 1;
  localparam int SW = ((ACC_W > DW) ? ACC_W : DW) + 1;
  localparam logic [SW-1:0] ACC_LIM = {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  logic             w_advance;
  logic             w_consume;
  logic [KW-1:0]    w_ke;

  logic             r1_valid;
  logic [WIDTH-1:0] r1_a;
  logic [WIDTH-1:0] r1_b;
  logic             r1_cin;
  logic [KW-1:0]    r1_ke;

  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_top;
  logic             w_c;
  logic [DW-1:0]    w_upper;
  logic [WIDTH-1:0] w_low;
  logic [DW-1:0]    w_approx;
  logic [DW-1:0]    w_exact;
  logic [DW-1:0]    w_d;

  logic             r2_valid;
  logic [DW-1:0]    r2_sum;
  logic [DW-1:0]    r2_d;

  logic [ACC_W-1:0] r_err_acc;
  logic [ACC_W-1:0] r_err_cnt;
  logic [DW-1:0]    r_err_max;
  logic [SW-1:0]    w_acc_sum;

  assign w_advance = !r2_valid || out_ready;
  assign w_consume = r2_valid && out_ready;
  assign in_ready  = w_advance;
  assign w_ke      = (K > KW'(MAX_K)) ? KW'(MAX_K) : K;

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid <= 1'b0;
    end else if (w_advance) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_a   <= A;
        r1_b   <= B;
        r1_cin <= Cin;
        r1_ke  <= w_ke;
      end
    end
  end

  // Masked operands leave zeros below Ke, so the upper add and the OR'd low part never overlap.
  always_comb begin
    w_mask   = (WIDTH'(1) << r1_ke) - WIDTH'(1);
    w_top    = w_mask ^ (w_mask >> 1);
    w_c      = (r1_ke == '0) ? r1_cin : |(r1_a & r1_b & w_top);
    w_upper  = {1'b0, r1_a & ~w_mask} + {1'b0, r1_b & ~w_mask} + (DW'(w_c) << r1_ke);
    w_low    = ((r1_a | r1_b) & w_mask) | WIDTH'(r1_cin && (r1_ke != '0));
    w_approx = w_upper | {1'b0, w_low};
    w_exact  = DW'(r1_a) + DW'(r1_b) + DW'(r1_cin);
    w_d      = (w_exact >= w_approx) ? (w_exact - w_approx) : (w_approx - w_exact);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r2_valid <= 1'b0;
      r2_sum   <= '0;
      r2_d     <= '0;
    end else if (w_advance) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_sum <= w_approx;
        r2_d   <= w_d;
      end
    end
  end

  assign out_valid   = r2_valid;
  assign {Cout, S}   = r2_sum;

  assign w_acc_sum = SW'(r_err_acc) + SW'(r2_d);

  // A clear wins over a simultaneous consume, so that result is never counted.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      r_err_acc <= '0;
      r_err_cnt <= '0;
      r_err_max <= '0;
    end else if (w_consume) begin
      r_err_acc <= (w_acc_sum > ACC_LIM) ? {ACC_W{1'b1}} : w_acc_sum[ACC_W-1:0];
      r_err_cnt <= (r_err_cnt == {ACC_W{1'b1}}) ? r_err_cnt : r_err_cnt + ACC_W'(1);
      r_err_max <= (r2_d > r_err_max) ? r2_d : r_err_max;
    end
  end

  assign err_acc = r_err_acc;
  assign err_cnt = r_err_cnt;
  assign err_max = r_err_max;

endmodule
